norm_shift_pipe: RTL and testbench

NORM_SHIFT_PIPE -- requirements
Module: norm_shift_pipe

---
 rtl/norm_shift_pipe.sv | 92 +++++++++
 tb/tb_norm_shift_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_shift_pipe.sv
// norm_shift_pipe: two-stage post-add normaliser (leading-zero count, then shift).
// Ports: clk_i/rst_i (sync active-high); valid_i/ready_o upstream handshake with
// PosSum_i, Exp_i, Sign_i, Minus_sticky_bit_i; valid_o/ready_i downstream handshake
// with Mant_o, Exp_o, Sign_o, Sticky_o, Zero_o.
// Define NORM_CANCEL_STATS_EN to add Cancel_cnt_o, a saturating count of deep cancellations.
module norm_shift_pipe #(
  parameter int PARM_EXP = 8,
  parameter int PARM_MANT = 23,
  localparam int W = 3*PARM_MANT+5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [W-1:0]          PosSum_i,
  input  logic [PARM_EXP+1:0]   Exp_i,
  input  logic                  Sign_i,
  input  logic                  Minus_sticky_bit_i,
`ifdef NORM_CANCEL_STATS_EN
  output logic [15:0]           Cancel_cnt_o,
`endif
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [PARM_MANT+2:0]  Mant_o,
  output logic [PARM_EXP+1:0]   Exp_o,
  output logic                  Sign_o,
  output logic                  Sticky_o,
  output logic                  Zero_o
);
  localparam int M = PARM_MANT+3;
  localparam int EW = PARM_EXP+2;
  localparam int LW = $clog2(W+1);
  logic s1_valid, s1_sign, s1_sticky, s1_zero, s2_free, s1_adv;
  logic [W-1:0] s1_sum, t;
  logic [EW-1:0] s1_exp;
  logic [LW-1:0] lzc, s1_lzc;
  // highest set bit wins because later iterations overwrite; all-zero leaves W
  always_comb begin
    lzc = LW'(W);
    for (int i = 0; i < W; i++) if (PosSum_i[i]) lzc = LW'(W-1-i);
  end
  assign s2_free = !valid_o || ready_i;
  assign s1_adv = s1_valid && s2_free;
  assign ready_o = !s1_valid || s2_free;
  assign s1_zero = s1_lzc == LW'(W);
  assign t = s1_sum << s1_lzc;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_sum <= '0;
      s1_exp <= '0;
      s1_sign <= 1'b0;
      s1_sticky <= 1'b0;
      s1_lzc <= '0;
    end else if (ready_o) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_sum <= PosSum_i;
        s1_exp <= Exp_i;
        s1_sign <= Sign_i;
        s1_sticky <= Minus_sticky_bit_i;
        s1_lzc <= lzc;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      Mant_o <= '0;
      Exp_o <= '0;
      Sign_o <= 1'b0;
      Sticky_o <= 1'b0;
      Zero_o <= 1'b0;
    end else if (s2_free) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        Mant_o <= t[W-1 -: M];
        Exp_o <= s1_zero ? '0 : s1_exp - EW'(s1_lzc);
        Sign_o <= s1_sign;
        Sticky_o <= (|t[W-M-1:0]) | s1_sticky;
        Zero_o <= s1_zero;
      end
    end
  end
`ifdef NORM_CANCEL_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) Cancel_cnt_o <= '0;
    else if (s1_adv && !s1_zero && s1_lzc > LW'(PARM_MANT+1) && Cancel_cnt_o != 16'hFFFF)
      Cancel_cnt_o <= Cancel_cnt_o + 16'd1;
  end
`endif
endmodule

// File: tb/tb_norm_shift_pipe.sv
// tb_norm_shift_pipe: scoreboard bench for norm_shift_pipe.
module tb_norm_shift_pipe;
  localparam int E = 8;
  localparam int MT = 23;
  localparam int W = 3*MT+5;
  localparam int M = MT+3;
  localparam int EW = E+2;
  typedef struct packed {
    logic [M-1:0] mant;
    logic [EW-1:0] exp;
    logic sign;
    logic sticky;
    logic zero;
  } res_t;
  logic clk = 0, rst = 1, valid_i = 0, ready_i = 1, sign_i = 0, st_i = 0;
  logic [W-1:0] sum_i = '0;
  logic [EW-1:0] exp_i = '0;
  logic ready_o, valid_o, Sign_o, Sticky_o, Zero_o;
  logic [M-1:0] Mant_o;
  logic [EW-1:0] Exp_o;
`ifdef NORM_CANCEL_STATS_EN
  logic [15:0] cnt;
`endif
  res_t q[$];
  res_t cur, prev, exp_r;
  logic prev_stall = 0;
  int n_chk = 0, n_fail = 0;
  norm_shift_pipe #(.PARM_EXP(E), .PARM_MANT(MT)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .PosSum_i(sum_i), .Exp_i(exp_i), .Sign_i(sign_i), .Minus_sticky_bit_i(st_i),
`ifdef NORM_CANCEL_STATS_EN
    .Cancel_cnt_o(cnt),
`endif
    .valid_o(valid_o), .ready_i(ready_i), .Mant_o(Mant_o), .Exp_o(Exp_o),
    .Sign_o(Sign_o), .Sticky_o(Sticky_o), .Zero_o(Zero_o)
  );
  always #5 clk = ~clk;
  assign cur = {Mant_o, Exp_o, Sign_o, Sticky_o, Zero_o};
  // normalise by shifting one place at a time until the top bit is set
  function automatic res_t model(input logic [W-1:0] s, input logic [EW-1:0] e, input logic sg, input logic st);
    res_t r;
    logic [W-1:0] t;
    int n;
    t = s;
    n = 0;
    r.sign = sg;
    if (s == '0) begin
      r.mant = '0; r.exp = '0; r.sticky = st; r.zero = 1'b1;
    end else begin
      while (!t[W-1]) begin t = t << 1; n++; end
      r.mant = t[W-1 -: M];
      r.exp = e - EW'(n);
      r.sticky = (|t[W-M-1:0]) | st;
      r.zero = 1'b0;
    end
    return r;
  endfunction
  // one cycle of stimulus; ready_o must be low exactly when both stages hold data and ready_i is low
  task automatic drive(input logic v, input logic [W-1:0] s, input logic [EW-1:0] e,
                       input logic sg, input logic st, input logic r, output logic acc);
    logic er;
    @(negedge clk);
    valid_i = v; sum_i = s; exp_i = e; sign_i = sg; st_i = st; ready_i = r;
    #1;
    er = !(q.size() == 2 && !r);
    n_chk++;
    if (ready_o !== er) begin
      n_fail++;
      $display("FAIL ready_o: got %b want %b (in flight %0d, ready_i %b)", ready_o, er, q.size(), r);
    end
    acc = v && ready_o;
    if (acc) q.push_back(model(s, e, sg, st));
  endtask
  always @(negedge clk) begin
    #2;
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        n_chk++;
        if ({valid_o, cur} !== {1'b1, prev}) begin
          n_fail++;
          $display("FAIL hold_stable: got v=%b %h want v=1 %h", valid_o, cur, prev);
        end
      end
      if (valid_o && ready_i) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %h want no result", cur);
        end else begin
          exp_r = q.pop_front();
          if (cur !== exp_r) begin
            n_fail++;
            $display("FAIL result: got mant=%h exp=%h s=%b st=%b z=%b want mant=%h exp=%h s=%b st=%b z=%b",
                     Mant_o, Exp_o, Sign_o, Sticky_o, Zero_o,
                     exp_r.mant, exp_r.exp, exp_r.sign, exp_r.sticky, exp_r.zero);
          end
        end
      end
      prev = cur;
      prev_stall = valid_o && !ready_i;
    end
  end
  task automatic drain();
    logic acc;
    for (int c = 0; c < 50 && q.size() > 0; c++) drive(0, '0, '0, 0, 0, 1, acc);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding want 0", q.size());
    end
  endtask
  function automatic logic [W-1:0] rand_sum();
    logic [95:0] rr;
    rr = {$urandom, $urandom, $urandom};
    if ($urandom_range(0, 15) == 0) return '0;
    return rr[W-1:0] >> $urandom_range(0, W-1);
  endfunction
  task automatic test_reset();
    @(negedge clk); rst = 1; valid_i = 0; ready_i = 1;
    @(negedge clk); #1;
    n_chk++;
    if ({valid_o, cur} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b %h want all zero", valid_o, cur);
    end
`ifdef NORM_CANCEL_STATS_EN
    n_chk++;
    if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", cnt); end
`endif
    @(negedge clk); rst = 0; #1;
    n_chk++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready_o=%b valid_o=%b want 1 0", ready_o, valid_o);
    end
  endtask
  task automatic test_directed();
    logic [W-1:0] vs[3];
    logic [EW-1:0] ve[3];
    res_t want[3];
    logic acc;
    vs[0] = {1'b1, {(W-1){1'b0}}}; vs[1] = 1; vs[2] = '0;
    ve[0] = 10; ve[1] = 10; ve[2] = 10'h155;
    want[0] = {26'h2000000, 10'd10, 1'b0, 1'b0, 1'b0};
    want[1] = {26'h2000000, 10'h3C1, 1'b0, 1'b0, 1'b0};
    want[2] = {26'h0, 10'h0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 3; k++) begin
      drive(1, vs[k], ve[k], k == 2, k == 2, 1, acc);
      drive(0, '0, '0, 0, 0, 1, acc);
      n_chk++;
      if (valid_o !== 1'b0) begin n_fail++; $display("FAIL latency_early_%0d: got valid_o=%b want 0", k, valid_o); end
      drive(0, '0, '0, 0, 0, 1, acc);
      n_chk++;
      if ({valid_o, cur} !== {1'b1, want[k]}) begin
        n_fail++;
        $display("FAIL directed_%0d: got v=%b %h want v=1 %h", k, valid_o, cur, want[k]);
      end
    end
`ifdef NORM_CANCEL_STATS_EN
    n_chk++;
    if (cnt !== 16'd1) begin n_fail++; $display("FAIL cancel_cnt_directed: got %0d want 1", cnt); end
`endif
    for (int k = 0; k < 8; k++) begin
      drive(1, rand_sum(), EW'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), 1, acc);
      n_chk++;
      if (!acc || (k >= 2 && valid_o !== 1'b1)) begin
        n_fail++;
        $display("FAIL throughput_%0d: got accept=%b valid_o=%b want 1 1", k, acc, valid_o);
      end
    end
    drain();
  endtask
  task automatic test_backpressure();
    logic [W-1:0] vs[4];
    logic acc, blocked;
    int k, stall;
    vs[0] = 74'h3; vs[1] = 74'h123456789; vs[2] = {2'b01, 72'hABCDEF}; vs[3] = 74'h1FFF_FFFF_FFFF;
    k = 0; stall = -1; blocked = 0;
    for (int c = 0; c < 40 && (k < 4 || q.size() > 0); c++) begin
      drive(k < 4, vs[k%4], EW'(20 + k), k[0], 0, !(stall > 0), acc);
      if (acc) k++;
      if (!ready_o) blocked = 1;
      if (stall > 0) stall--;
      else if (stall < 0 && valid_o) stall = 3;
    end
    n_chk++;
    if (k != 4 || q.size() != 0 || !blocked) begin
      n_fail++;
      $display("FAIL backpressure: got accepted=%0d pending=%0d blocked=%b want 4 0 1", k, q.size(), blocked);
    end
  endtask
  task automatic test_back_to_back();
    logic acc;
    int k;
    k = 0;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, rand_sum(), EW'($urandom), $urandom_range(0, 1),
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, acc);
      if (acc) k++;
    end
    drain();
    n_chk++;
    if (k < 100) begin n_fail++; $display("FAIL random_accepts: got %0d want >= 100", k); end
  endtask
  task automatic test_reset_flush();
    logic acc;
    drive(1, 74'h5, 10'd3, 0, 0, 0, acc);
    drive(1, 74'h7, 10'd4, 1, 0, 0, acc);
    drive(1, 74'h9, 10'd5, 0, 0, 0, acc);
    n_chk++;
    if (valid_o !== 1'b1 || q.size() != 2) begin
      n_fail++;
      $display("FAIL flush_fill: got valid_o=%b pending=%0d want 1 2", valid_o, q.size());
    end
    @(negedge clk); rst = 1; valid_i = 0; ready_i = 1; q.delete();
    @(negedge clk); rst = 0; #1;
    n_chk++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_reset: got valid_o=%b ready_o=%b want 0 1", valid_o, ready_o);
    end
    for (int c = 0; c < 5; c++) begin
      drive(0, '0, '0, 0, 0, 1, acc);
      n_chk++;
      if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_stale_%0d: got valid_o=%b want 0", c, valid_o); end
    end
  endtask
`ifdef NORM_CANCEL_STATS_EN
  task automatic test_cancel_saturate();
    logic acc;
    for (int c = 0; c < 1000; c++) drive(1, 74'h1, 10'd0, 0, 0, 1, acc);
    drain();
    n_chk++;
    if (cnt !== 16'd1000) begin n_fail++; $display("FAIL cancel_cnt_1000: got %0d want 1000", cnt); end
    for (int c = 0; c < 69000; c++) drive(1, 74'h1, 10'd0, 0, 0, 1, acc);
    drain();
    n_chk++;
    if (cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cancel_cnt_sat: got %h want ffff", cnt); end
    for (int c = 0; c < 10; c++) drive(1, 74'h1, 10'd0, 0, 0, 1, acc);
    drain();
    n_chk++;
    if (cnt !== 16'hFFFF) begin n_fail++; $display("FAIL cancel_cnt_hold: got %h want ffff", cnt); end
  endtask
`endif
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_flush();
`ifdef NORM_CANCEL_STATS_EN
    test_cancel_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
